// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: the run-control bus between a test harness (master) and the
// cpu_run_ctrl block (slave).
// The harness issues start and reports the CPU's program counter.
// The controller returns the CPU reset, the run status, the cycle count and the
// final PC.
// When CPU_RUN_CTRL_TRACE_EN is defined, the bus also carries the PC-change trace
// (trace_valid, trace_pc).
interface cpu_run_ctrl_if #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 32
);
    logic                 start;
    logic [PC_WIDTH-1:0]  pc_in;
    logic                 cpu_reset;
    logic                 running;
    logic                 done;
    logic                 timeout;
    logic [CNT_WIDTH-1:0] cycle_count;
    logic [PC_WIDTH-1:0]  final_pc;
`ifdef CPU_RUN_CTRL_TRACE_EN
    logic                 trace_valid;
    logic [PC_WIDTH-1:0]  trace_pc;
`endif

    // Harness side: drives the run request and the observed PC.
    modport master (
        output start,
        output pc_in,
        input  cpu_reset,
        input  running,
        input  done,
        input  timeout,
        input  cycle_count,
        input  final_pc
`ifdef CPU_RUN_CTRL_TRACE_EN
        ,
        input  trace_valid,
        input  trace_pc
`endif
    );

    // Controller side.
    modport slave (
        input  start,
        input  pc_in,
        output cpu_reset,
        output running,
        output done,
        output timeout,
        output cycle_count,
        output final_pc
`ifdef CPU_RUN_CTRL_TRACE_EN
        ,
        output trace_valid,
        output trace_pc
`endif
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller for CPU bring-up.
// It holds the core in reset for RST_CYCLES after start, and then counts RUN cycles.
// A run ends in one of two ways:
//   - HALT: the PC stays unchanged for STALL_LIMIT consecutive cycles.
//   - TOUT: MAX_CYCLES RUN cycles elapse.
// If both happen on the same cycle, HALT wins.
// The controller re-asserts the core reset after HALT or TOUT, so the core stays frozen.
// Optional PC-change trace: define CPU_RUN_CTRL_TRACE_EN.
module cpu_run_ctrl #(
    parameter int PC_WIDTH    = 32,
    parameter int CNT_WIDTH   = 32,
    parameter int RST_CYCLES  = 2,
    parameter int STALL_LIMIT = 8,
    parameter int MAX_CYCLES  = 600
) (
    input logic           CLK,
    input logic           RESET,
    cpu_run_ctrl_if.slave bus
);

    // Counter widths sized to the largest value each counter ever holds.
    localparam int RST_W   = (RST_CYCLES  > 1) ? $clog2(RST_CYCLES)  : 1;
    localparam int STALL_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;

    localparam logic [RST_W-1:0]     RST_LAST   = RST_W'(RST_CYCLES - 1);
    localparam logic [STALL_W-1:0]   STALL_LAST = STALL_W'(STALL_LIMIT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'(MAX_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_RUN,
        ST_HALT,
        ST_TOUT
    } state_t;

    state_t               state_reg;
    logic [RST_W-1:0]     rst_cnt_reg;
    logic [STALL_W-1:0]   stall_cnt_reg;
    logic [PC_WIDTH-1:0]  prev_pc_reg;
    logic [CNT_WIDTH-1:0] cycle_count_reg;
    logic [PC_WIDTH-1:0]  final_pc_reg;
    logic                 cpu_reset_reg;
    logic                 running_reg;
    logic                 done_reg;
    logic                 timeout_reg;

    // The halt and timeout conditions are decided from the current PC sample.
    logic pc_equal;
    logic halt_hit;
    logic tout_hit;

    // Decode this cycle's halt and timeout conditions.
    always_comb begin
        pc_equal = (bus.pc_in == prev_pc_reg);
        halt_hit = pc_equal && (stall_cnt_reg == STALL_LAST);
        tout_hit = (cycle_count_reg == CNT_LAST);
    end

    // Run sequencer: state, counters and registered status outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg       <= ST_IDLE;
            rst_cnt_reg     <= '0;
            stall_cnt_reg   <= '0;
            prev_pc_reg     <= '0;
            cycle_count_reg <= '0;
            final_pc_reg    <= '0;
            cpu_reset_reg   <= 1'b1;
            running_reg     <= 1'b0;
            done_reg        <= 1'b0;
            timeout_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    cpu_reset_reg <= 1'b1;
                    running_reg   <= 1'b0;
                    done_reg      <= 1'b0;
                    timeout_reg   <= 1'b0;
                    if (bus.start) begin
                        state_reg       <= ST_RST;
                        rst_cnt_reg     <= '0;
                        cycle_count_reg <= '0;
                    end
                end

                ST_RST: begin
                    // Arm the stall detector with the PC the core sits at
                    // when it comes out of reset.
                    stall_cnt_reg <= '0;
                    prev_pc_reg   <= bus.pc_in;
                    if (rst_cnt_reg == RST_LAST) begin
                        state_reg     <= ST_RUN;
                        cpu_reset_reg <= 1'b0;
                        running_reg   <= 1'b1;
                    end else begin
                        rst_cnt_reg <= rst_cnt_reg + RST_W'(1);
                    end
                end

                ST_RUN: begin
                    prev_pc_reg     <= bus.pc_in;
                    cycle_count_reg <= cycle_count_reg + CNT_WIDTH'(1);
                    if (!pc_equal) begin
                        stall_cnt_reg <= '0;
                    end else if (stall_cnt_reg != STALL_LAST) begin
                        stall_cnt_reg <= stall_cnt_reg + STALL_W'(1);
                    end

                    // Check halt first, so a halt that coincides with the
                    // timeout is reported as a halt.
                    if (halt_hit) begin
                        state_reg     <= ST_HALT;
                        final_pc_reg  <= bus.pc_in;
                        cpu_reset_reg <= 1'b1;
                        running_reg   <= 1'b0;
                        done_reg      <= 1'b1;
                    end else if (tout_hit) begin
                        state_reg     <= ST_TOUT;
                        final_pc_reg  <= bus.pc_in;
                        cpu_reset_reg <= 1'b1;
                        running_reg   <= 1'b0;
                        done_reg      <= 1'b1;
                        timeout_reg   <= 1'b1;
                    end
                end

                ST_HALT, ST_TOUT: begin
                    // The core stays frozen until the next start.
                    // final_pc keeps the last result across the restart.
                    cpu_reset_reg <= 1'b1;
                    running_reg   <= 1'b0;
                    if (bus.start) begin
                        state_reg       <= ST_RST;
                        rst_cnt_reg     <= '0;
                        cycle_count_reg <= '0;
                        done_reg        <= 1'b0;
                        timeout_reg     <= 1'b0;
                    end
                end

                default: begin
                    state_reg     <= ST_IDLE;
                    cpu_reset_reg <= 1'b1;
                    running_reg   <= 1'b0;
                    done_reg      <= 1'b0;
                    timeout_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_reset   = cpu_reset_reg;
    assign bus.running     = running_reg;
    assign bus.done        = done_reg;
    assign bus.timeout     = timeout_reg;
    assign bus.cycle_count = cycle_count_reg;
    assign bus.final_pc    = final_pc_reg;

`ifdef CPU_RUN_CTRL_TRACE_EN
    logic                trace_valid_reg;
    logic [PC_WIDTH-1:0] trace_pc_reg;

    // PC-change trace: in RUN, pulse once for every new PC value.
    // trace_pc holds the last value that was traced.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            trace_valid_reg <= 1'b0;
            trace_pc_reg    <= '0;
        end else if (state_reg == ST_RUN && !pc_equal) begin
            trace_valid_reg <= 1'b1;
            trace_pc_reg    <= bus.pc_in;
        end else begin
            trace_valid_reg <= 1'b0;
        end
    end

    assign bus.trace_valid = trace_valid_reg;
    assign bus.trace_pc    = trace_pc_reg;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: self-checking bench for cpu_run_ctrl.
// The bench is organised as follows:
//   - A table of per-cycle vectors covers reset release, the reset window, and a
//     stall that leads to a halt.
//   - Hand-written sequences cover:
//       - a halt that coincides with the timeout,
//       - a plain timeout and a restart,
//       - an asynchronous reset in the middle of a run,
//       - the trace port, when it is built in.
//   - A randomised phase is checked against a run-level reference model.
//     The model decides a halt from the recent PC history and a timeout from the
//     number of RUN cycles.
module tb_cpu_run_ctrl;

    localparam int PW = 16;
    localparam int CW = 16;
    localparam int RC = 3;   // RST_CYCLES
    localparam int SL = 5;   // STALL_LIMIT
    localparam int MC = 24;  // MAX_CYCLES

    localparam int P_IDLE = 0;
    localparam int P_RST  = 1;
    localparam int P_RUN  = 2;
    localparam int P_HALT = 3;
    localparam int P_TOUT = 4;

    logic CLK;
    logic RESET;

    cpu_run_ctrl_if #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

    cpu_run_ctrl #(
        .PC_WIDTH   (PW),
        .CNT_WIDTH  (CW),
        .RST_CYCLES (RC),
        .STALL_LIMIT(SL),
        .MAX_CYCLES (MC)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int n_runs   = 0;

    // Reference model state.
    int          m_phase;
    int          m_since;   // RST cycles taken since start
    logic [CW-1:0] m_cc;
    logic [PW-1:0] m_fpc;
    logic          m_tv;
    logic [PW-1:0] m_tpc;
    logic [PW-1:0] m_hist[$]; // PC samples since the core left reset

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_since = 0;
        m_cc    = '0;
        m_fpc   = '0;
        m_tv    = 1'b0;
        m_tpc   = '0;
        m_hist.delete();
    endtask

    // A halt means the last SL+1 PC samples are all identical.
    // That is SL consecutive cycles in which the PC did not move.
    function automatic bit model_stalled();
        int n = m_hist.size();
        if (n < SL + 1) return 1'b0;
        for (int i = n - SL - 1; i < n; i++)
            if (m_hist[i] != m_hist[n-1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input logic st, input logic [PW-1:0] pc);
        logic [PW-1:0] prev;
        m_tv = 1'b0;
        case (m_phase)
            P_IDLE, P_HALT, P_TOUT: begin
                if (st) begin
                    m_phase = P_RST;
                    m_since = 0;
                    m_cc    = '0;
                end
            end
            P_RST: begin
                m_since++;
                if (m_since == RC) begin
                    m_phase = P_RUN;
                    m_hist.delete();
                    m_hist.push_back(pc);
                end
            end
            P_RUN: begin
                prev = m_hist[$];
                m_hist.push_back(pc);
                m_cc = m_cc + 1'b1;
                if (pc != prev) begin
                    m_tv  = 1'b1;
                    m_tpc = pc;
                end
                if (model_stalled()) begin
                    m_phase = P_HALT;
                    m_fpc   = pc;
                end else if (int'(m_cc) == MC) begin
                    m_phase = P_TOUT;
                    m_fpc   = pc;
                end
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".cpu_reset"},   bus.cpu_reset,   (m_phase != P_RUN));
        chk({tag, ".running"},     bus.running,     (m_phase == P_RUN));
        chk({tag, ".done"},        bus.done,        (m_phase == P_HALT || m_phase == P_TOUT));
        chk({tag, ".timeout"},     bus.timeout,     (m_phase == P_TOUT));
        chk({tag, ".cycle_count"}, bus.cycle_count, m_cc);
        chk({tag, ".final_pc"},    bus.final_pc,    m_fpc);
`ifdef CPU_RUN_CTRL_TRACE_EN
        chk({tag, ".trace_valid"}, bus.trace_valid, m_tv);
        chk({tag, ".trace_pc"},    bus.trace_pc,    m_tpc);
`endif
    endtask

    // One clock: inputs are driven at the falling edge, and the outputs are
    // checked at the next falling edge.
    task automatic tick(input logic st, input logic [PW-1:0] pc, input string tag);
        int old_phase = m_phase;
        bus.start = st;
        bus.pc_in = pc;
        @(posedge CLK);
        model_step(st, pc);
        @(negedge CLK);
        check_model(tag);
        if (old_phase == P_RUN && m_phase != P_RUN) begin
            n_runs++;
            $display("run %0d: %s after %0d cycles, final_pc=%0h", n_runs,
                     (m_phase == P_HALT) ? "halt" : "timeout", m_cc, m_fpc);
        end
    endtask

    // Asynchronous reset pulse, raised between clock edges.
    // The outputs must clear without waiting for a clock.
    task automatic reset_pulse(input string tag);
        #2 RESET = 1'b1;
        #1;
        model_reset();
        chk({tag, ".async_cpu_reset"},   bus.cpu_reset,   1'b1);
        chk({tag, ".async_running"},     bus.running,     1'b0);
        chk({tag, ".async_done"},        bus.done,        1'b0);
        chk({tag, ".async_cycle_count"}, bus.cycle_count, '0);
        chk({tag, ".async_final_pc"},    bus.final_pc,    '0);
        check_model(tag);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    // Issue start and measure how many cycles cpu_reset stays high.
    // On return the controller is in RUN.
    task automatic start_run(input string tag);
        int hi = 1;
        tick(1'b1, '0, tag);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, '0, tag);
            if (!bus.cpu_reset) break;
            hi++;
        end
        chk({tag, ".reset_width"}, hi, RC);
    endtask

    typedef struct {
        logic          st;
        logic [PW-1:0] pc;
        logic          e_cr;
        logic          e_run;
        logic          e_done;
        logic          e_to;
        logic [CW-1:0] e_cc;
        logic [PW-1:0] e_fpc;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] pc_r;

        // Per-cycle vectors. Each row gives the inputs before a clock edge and the
        // expected outputs after that edge.
        //          st    pc      cr    run   done  to    cc     fpc
        vecs[0]  = '{1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};  // idle
        vecs[1]  = '{1'b1, 16'd0,  1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};  // start
        vecs[2]  = '{1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[3]  = '{1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[4]  = '{1'b0, 16'd0,  1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};  // RUN
        vecs[5]  = '{1'b0, 16'd4,  1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0};
        vecs[6]  = '{1'b0, 16'd8,  1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 16'd0};
        vecs[7]  = '{1'b0, 16'd12, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 16'd0};  // first 12
        vecs[8]  = '{1'b0, 16'd12, 1'b0, 1'b1, 1'b0, 1'b0, 16'd4, 16'd0};
        vecs[9]  = '{1'b0, 16'd12, 1'b0, 1'b1, 1'b0, 1'b0, 16'd5, 16'd0};
        vecs[10] = '{1'b0, 16'd12, 1'b0, 1'b1, 1'b0, 1'b0, 16'd6, 16'd0};
        vecs[11] = '{1'b0, 16'd12, 1'b0, 1'b1, 1'b0, 1'b0, 16'd7, 16'd0};
        vecs[12] = '{1'b0, 16'd12, 1'b1, 1'b0, 1'b1, 1'b0, 16'd8, 16'd12}; // halt
        vecs[13] = '{1'b0, 16'd20, 1'b1, 1'b0, 1'b1, 1'b0, 16'd8, 16'd12}; // frozen
        vecs[14] = '{1'b1, 16'd0,  1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd12}; // restart

        RESET     = 1'b1;
        bus.start = 1'b0;
        bus.pc_in = '0;
        model_reset();
        @(negedge CLK);
        chk("reset.cpu_reset",   bus.cpu_reset,   1'b1);
        chk("reset.running",     bus.running,     1'b0);
        chk("reset.done",        bus.done,        1'b0);
        chk("reset.timeout",     bus.timeout,     1'b0);
        chk("reset.cycle_count", bus.cycle_count, '0);
        chk("reset.final_pc",    bus.final_pc,    '0);
        @(negedge CLK);
        RESET = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 15; i++) begin
            bus.start = vecs[i].st;
            bus.pc_in = vecs[i].pc;
            @(posedge CLK);
            model_step(vecs[i].st, vecs[i].pc);
            @(negedge CLK);
            chk($sformatf("vec%0d.cpu_reset", i),   bus.cpu_reset,   vecs[i].e_cr);
            chk($sformatf("vec%0d.running", i),     bus.running,     vecs[i].e_run);
            chk($sformatf("vec%0d.done", i),        bus.done,        vecs[i].e_done);
            chk($sformatf("vec%0d.timeout", i),     bus.timeout,     vecs[i].e_to);
            chk($sformatf("vec%0d.cycle_count", i), bus.cycle_count, vecs[i].e_cc);
            chk($sformatf("vec%0d.final_pc", i),    bus.final_pc,    vecs[i].e_fpc);
            $display("vec %0d: start=%0b pc=%0h -> cpu_reset=%0b running=%0b done=%0b cc=%0d",
                     i, vecs[i].st, vecs[i].pc, bus.cpu_reset, bus.running, bus.done,
                     bus.cycle_count);
        end

        // Halt and timeout land on the same cycle. The PC moves on RUN cycles
        // 1..19, then holds for SL cycles, ending exactly on cycle MC.
        reset_pulse("coinc");
        start_run("coinc");
        for (int k = 1; k <= MC - SL; k++) tick(1'b0, PW'(4 * k), "coinc");
        for (int k = 0; k < SL; k++) tick(1'b0, PW'(4 * (MC - SL)), "coinc");
        chk("coinc.done",        bus.done,        1'b1);
        chk("coinc.timeout",     bus.timeout,     1'b0);
        chk("coinc.cycle_count", bus.cycle_count, CW'(MC));
        chk("coinc.final_pc",    bus.final_pc,    PW'(4 * (MC - SL)));
        $display("coincident halt/timeout: done=%0b timeout=%0b cc=%0d", bus.done,
                 bus.timeout, bus.cycle_count);

        // Restart from HALT, and run with a PC that never stalls.
        start_run("tout");
        for (int k = 1; k <= MC; k++) tick(1'b0, PW'(4 * k), "tout");
        chk("tout.timeout",     bus.timeout,     1'b1);
        chk("tout.done",        bus.done,        1'b1);
        chk("tout.cycle_count", bus.cycle_count, CW'(MC));
        chk("tout.final_pc",    bus.final_pc,    PW'(4 * MC));
        repeat (2) tick(1'b0, 16'h55, "tout_hold");
        chk("tout.hold_cc",     bus.cycle_count, CW'(MC));
        $display("timeout run: timeout=%0b cc=%0d final_pc=%0h", bus.timeout,
                 bus.cycle_count, bus.final_pc);

        // Asynchronous reset on RUN cycle 5.
        start_run("midrst");
        for (int k = 1; k <= 5; k++) tick(1'b0, PW'(8 * k), "midrst");
        reset_pulse("midrst");
        $display("mid-run reset: cpu_reset=%0b running=%0b cc=%0d", bus.cpu_reset,
                 bus.running, bus.cycle_count);

`ifdef CPU_RUN_CTRL_TRACE_EN
        // Trace the PC sequence 0,4,4,8.
        start_run("trace");
        tick(1'b0, 16'd4, "trace");
        chk("trace.v1",  bus.trace_valid, 1'b1);
        chk("trace.pc1", bus.trace_pc,    16'd4);
        tick(1'b0, 16'd4, "trace");
        chk("trace.v2",  bus.trace_valid, 1'b0);
        tick(1'b0, 16'd8, "trace");
        chk("trace.v3",  bus.trace_valid, 1'b1);
        chk("trace.pc3", bus.trace_pc,    16'd8);
        $display("trace: last trace_pc=%0h", bus.trace_pc);
        reset_pulse("trace");
`endif

        // Random phase: frequent PC holds give a mix of halts and timeouts.
        pc_r = '0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) >= 60) pc_r = PW'($urandom_range(0, 7) * 4);
            tick(($urandom_range(0, 7) == 0), pc_r, "rand");
            if ($urandom_range(0, 199) == 0) reset_pulse("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
